// File: rtl/ud_counter_pkg.sv
// Shared definitions for the 4-bit up/down counter and its receive-side checker.
// Holds the default geometry, the checker state encodings and the counter next-value rule.
package ud_counter_pkg;

  localparam int unsigned DEF_W = 4;
  localparam logic [DEF_W-1:0] DEF_PRESET_VAL = {DEF_W{1'b1}};

  localparam logic [1:0] ACQ    = 2'd0;
  localparam logic [1:0] TRACK  = 2'd1;
  localparam logic [1:0] RELOCK = 2'd2;

  typedef enum logic [1:0] {
    StAcq    = ACQ,
    StTrack  = TRACK,
    StRelock = RELOCK
  } state_e;

  // Counter next-value rule on a value held in the low bits of a 32-bit word; mask sets the width.
  function automatic logic [31:0] nxt(input logic [31:0] v, input logic [31:0] preset_val,
                                      input logic [31:0] mask, input logic en, input logic ud,
                                      input logic clr, input logic preset);
    logic [31:0] r;
    if (clr) begin
      r = '0;
    end else if (preset) begin
      r = preset_val;
    end else if (en && ud) begin
      r = v + 32'd1;
    end else if (en) begin
      r = v - 32'd1;
    end else begin
      r = v;
    end
    return r & mask;
  endfunction

endpackage

// File: rtl/up_down_count_checker_if.sv
// Control and count-output signals of the monitored up/down counter.
// The counter side (or bench) drives through master; the checker observes through slave.
interface up_down_count_checker_if #(
  parameter int unsigned W = ud_counter_pkg::DEF_W
);
  logic         mon_en;
  logic         mon_ud;
  logic         mon_clr;
  logic         mon_preset;
  logic         mon_oe;
  logic [W-1:0] cnt_in;

  modport master (
    output mon_en, mon_ud, mon_clr, mon_preset, mon_oe, cnt_in
  );

  modport slave (
    input mon_en, mon_ud, mon_clr, mon_preset, mon_oe, cnt_in
  );
endinterface

// File: rtl/ud_shadow_model.sv
// Shadow copy of the monitored counter: W-bit register, next-value rule, wrap and direction.
// The step base is either the observed count (resync) or the shadow itself.
module ud_shadow_model
  import ud_counter_pkg::*;
#(
  parameter int unsigned    W          = DEF_W,
  parameter logic [W-1:0]   PRESET_VAL = {W{1'b1}}
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         ud,
  input  logic         clr,
  input  logic         preset,
  input  logic         use_obs,
  input  logic [W-1:0] obs,
  output logic [W-1:0] cnt,
  output logic         wrap,
  output logic         dir_up
);

  localparam logic [31:0] Mask = {{(32 - W){1'b0}}, {W{1'b1}}};

  logic [W-1:0] base;
  logic [31:0]  nxt_word;
  logic         step;
  logic         wrap_d;
  logic         dir_d;
  logic         unused_hi;

  assign base     = use_obs ? obs : cnt;
  assign nxt_word = nxt(32'(base), 32'(PRESET_VAL), Mask, en, ud, clr, preset);
  assign unused_hi = ^nxt_word[31:W];

  // Only a plain enable step counts as a direction change or a boundary crossing.
  assign step   = en & ~clr & ~preset;
  assign wrap_d = step & (ud ? (base == {W{1'b1}}) : (base == '0));
  assign dir_d  = step ? ud : dir_up;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt    <= '0;
      wrap   <= 1'b0;
      dir_up <= 1'b1;
    end else begin
      cnt    <= nxt_word[W-1:0];
      wrap   <= wrap_d;
      dir_up <= dir_d;
    end
  end

endmodule

// File: rtl/up_down_count_checker.sv
// Receive-side monitor for the up/down counter: acquires, tracks and relocks a shadow count,
// flagging miscompares while locked and keeping a sticky flag and saturating error count.
module up_down_count_checker
  import ud_counter_pkg::*;
#(
  parameter int unsigned  W          = DEF_W,
  parameter logic [W-1:0] PRESET_VAL = {W{1'b1}},
  parameter int unsigned  LOCK_CNT   = 4,
  parameter int unsigned  ERR_W      = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  up_down_count_checker_if.slave   mon,
  input  logic                     err_clr,
  output logic                     locked,
  output logic [W-1:0]             exp_cnt,
  output logic                     mismatch,
  output logic                     wrap,
  output logic                     dir_up,
  output logic                     err_sticky,
  output logic [ERR_W-1:0]         err_cnt
);

  localparam logic [4:0] LockCnt = 5'(LOCK_CNT);

  state_e           state_q, state_d;
  logic [3:0]       match_q, match_d;
  logic [4:0]       match_inc;
  logic             valid, hit, miss_err;
  logic             err_sticky_d;
  logic [ERR_W-1:0] err_cnt_d;

  assign valid     = mon.mon_oe;
  assign hit       = (mon.cnt_in == exp_cnt);
  assign match_inc = {1'b0, match_q} + 5'd1;
  assign locked    = (state_q == StTrack);

  // On a valid sample the shadow always steps from cnt_in: equal to exp_cnt on a match,
  // and the resync value on a miscompare or during acquisition.
  ud_shadow_model #(
    .W          (W),
    .PRESET_VAL (PRESET_VAL)
  ) u_shadow (
    .clk     (clk),
    .rst     (rst),
    .en      (mon.mon_en),
    .ud      (mon.mon_ud),
    .clr     (mon.mon_clr),
    .preset  (mon.mon_preset),
    .use_obs (valid),
    .obs     (mon.cnt_in),
    .cnt     (exp_cnt),
    .wrap    (wrap),
    .dir_up  (dir_up)
  );

  always_comb begin
    state_d  = state_q;
    match_d  = match_q;
    miss_err = 1'b0;
    if (valid) begin
      unique case (state_q)
        StAcq: begin
          match_d = 4'd1;
          state_d = (LOCK_CNT == 1) ? StTrack : StRelock;
        end
        StTrack: begin
          if (!hit) begin
            miss_err = 1'b1;
            match_d  = 4'd1;
            state_d  = StRelock;
          end
        end
        StRelock: begin
          if (hit) begin
            match_d = match_inc[3:0];
            if (match_inc >= LockCnt) state_d = StTrack;
          end else begin
            match_d = 4'd1;
          end
        end
        default: begin
          state_d = StAcq;
          match_d = '0;
        end
      endcase
    end
  end

  // A mismatch on the same edge as err_clr still registers as one error.
  always_comb begin
    err_sticky_d = err_clr ? 1'b0 : err_sticky;
    err_cnt_d    = err_clr ? '0 : err_cnt;
    if (miss_err) begin
      err_sticky_d = 1'b1;
      if (err_cnt_d != {ERR_W{1'b1}}) err_cnt_d = err_cnt_d + ERR_W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StAcq;
      match_q    <= '0;
      mismatch   <= 1'b0;
      err_sticky <= 1'b0;
      err_cnt    <= '0;
    end else begin
      state_q    <= state_d;
      match_q    <= match_d;
      mismatch   <= miss_err;
      err_sticky <= err_sticky_d;
      err_cnt    <= err_cnt_d;
    end
  end

endmodule
